axi_lite_bram_ctrl: RTL and testbench
=====================================

Name: axi_lite_bram_ctrl

Overview:
AXI4-Lite slave that converts single-beat processor reads and writes into BRAM port transactions. It drives one port (A or B) of the 16 KB dual-port instruction/data BRAM block, which uses 32-bit big-endian [0:31] buses and four byte write enables. It sits directly upstream of that BRAM block, between the AXI interconnect and the BRAM port.

Parameters:
C_BASEADDR, 32'h0000_0000, AXI base address of the BRAM window.
C_MEMSIZE, 'h4000, window size in bytes; power of two.
C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
C_PORT_AWIDTH, 32, BRAM_Addr width.
C_NUM_WE, 4, byte write enables.

Ports:
S_AXI_ACLK  in  1  single clock; also forwarded to BRAM_Clk.
S_AXI_ARESET  in  1  reset, asynchronous, active-high.
S_AXI_AWADDR  in  32  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  32  write data [31:0].
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  write response, always 2'b00.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  32  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response, always 2'b00.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
BRAM_Rst  out  1  equals S_AXI_ARESET.
BRAM_Clk  out  1  equals S_AXI_ACLK.
BRAM_EN  out  1  port enable.
BRAM_WEN  out  [0:3]  byte write enables; bit 0 covers BRAM bits [0:7].
BRAM_Addr  out  [0:31]  byte address.
BRAM_Dout  out  [0:31]  write data to BRAM.
BRAM_Din  in  [0:31]  read data from BRAM.

Behaviour:
- Reset, asynchronous, all outputs: all READY/VALID = 0, BRAM_EN = 0, BRAM_WEN = 0, BRAM_Addr = 0, BRAM_Dout = 0, S_AXI_RDATA = 0, state IDLE, last_grant = READ. Assertion mid-transaction drops the transaction and issues no response.
- FSM states: IDLE, WR_BRAM, WR_RESP, RD_BRAM, RD_WAIT, RD_RESP.
- IDLE:
  - Write is eligible only when AWVALID and WVALID are both high.
  - Read is eligible when ARVALID is high.
  - If both are eligible, grant the one opposite to last_grant (round-robin).
  - Grant means a one-cycle pulse of AWREADY and WREADY together (or ARREADY alone); address and data/strobes are latched on that edge and last_grant is updated.
  - AWVALID without WVALID is never accepted.
- Address: offset = (ADDR - C_BASEADDR) & (C_MEMSIZE-1) with bits [1:0] forced to 0. BRAM_Addr carries the offset (LSB = BRAM_Addr[31]); all other bits are 0. No decode error is generated.
- Write:
  - WR_BRAM (one cycle): BRAM_EN = 1; BRAM_WEN[i] = WSTRB[3-i]; BRAM_Dout = WDATA, so BRAM_Dout[0] = WDATA[31].
  - WR_RESP: BVALID = 1 until the cycle BREADY is sampled high, then IDLE.
  - Handshake edge T → BRAM write at T+1 → BVALID from T+2. WSTRB = 0 still performs an enabled cycle with WEN = 0 and returns OKAY.
- Read:
  - RD_BRAM (one cycle): BRAM_EN = 1, WEN = 0.
  - RD_WAIT: capture BRAM_Din into RDATA, so RDATA[31] = BRAM_Din[0].
  - RD_RESP: RVALID = 1 until RREADY is sampled high.
  - ARREADY edge T → RVALID from T+3. RDATA holds stable while RVALID is high and BRAM_EN = 0.
- BRAM_EN and BRAM_WEN are 0 in every state except WR_BRAM and RD_BRAM.
- Only one transaction is outstanding; no READY is asserted outside IDLE.
- BREADY or RREADY already high when VALID rises: completes in that cycle; the FSM is back in IDLE the next cycle.

Test Plan:
- Write 0xDEADBEEF to C_BASEADDR+0x10 with WSTRB = 4'hF → BRAM_EN = 1, BRAM_WEN = 4'b1111, BRAM_Addr = 0x10, BRAM_Dout[0:7] = 0xDE; BVALID 2 cycles after handshake; BRESP = 0.
- Write WSTRB = 4'b0001 with data 0x000000AA to 0x20 → BRAM_WEN = 4'b0001 (bits [24:31] only); a subsequent read returns 0x112233AA when the word was preloaded with 0x11223344.
- Read 0x3FFC with BRAM model returning 0xCAFEF00D → RVALID exactly 3 cycles after ARREADY, RDATA = 0xCAFEF00D; hold RREADY low 5 cycles → RDATA/RVALID stable.
- AW/W and AR all valid in the same cycle, repeated 4 times → grants alternate W, R, W, R (last_grant starts READ); no starvation.
- Address C_BASEADDR+0x4003 → BRAM_Addr = 0x0000 (wrap and alignment).
- Assert S_AXI_ARESET during RD_WAIT → BRAM_EN, RVALID, ARREADY go 0 immediately; after release a new read completes normally.

Source files
------------

// File: rtl/axi_lite_bram_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_bram_ctrl
//   AXI4-Lite slave that turns single-beat reads and writes into transactions
//   on one port of a big-endian ([0:31]) dual-port BRAM block.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET  clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*       write address / data channels
//   S_AXI_B*                   write response channel (always OKAY)
//   S_AXI_AR* / S_AXI_R*       read address / data channels (always OKAY)
//   BRAM_*                     BRAM port: clock, reset, enable, byte write
//                              enables, byte address, write and read data
//   o_dbg_state                current FSM state, for observation only
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where both VALID and READY are high; the slave raises READY only in
// IDLE, for exactly one cycle, and holds VALID until the matching READY.
// ---------------------------------------------------------------------------
module axi_lite_bram_ctrl #(
  parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
  parameter int          C_MEMSIZE          = 'h4000,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_PORT_AWIDTH      = 32,
  parameter int          C_NUM_WE           = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [31:0]                   S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_NUM_WE-1:0]           S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [31:0]                   S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          BRAM_Rst,
  output logic                          BRAM_Clk,
  output logic                          BRAM_EN,
  output logic [0:C_NUM_WE-1]           BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1]      BRAM_Addr,
  output logic [0:C_S_AXI_DATA_WIDTH-1] BRAM_Dout,
  input  logic [0:C_S_AXI_DATA_WIDTH-1] BRAM_Din,
  output logic [2:0]                    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_BRAM = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_BRAM = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_RESP = 3'd5
  } state_t;

  // Offset inside the window, word aligned (the two byte-lane bits dropped).
  localparam logic [31:0] LP_OFF_MASK = (32'(C_MEMSIZE) - 32'd1) & 32'hFFFF_FFFC;

  state_t                          r_state;
  logic                            r_wr_ready;   // drives AWREADY and WREADY together
  logic                            r_ar_ready;
  logic                            r_bvalid;
  logic                            r_rvalid;
  logic                            r_last_wr;    // 1: last grant was a write
  logic                            r_en;
  logic [C_NUM_WE-1:0]             r_wen;
  logic [C_PORT_AWIDTH-1:0]        r_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_dout;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;

  logic [31:0] w_aw_off;
  logic [31:0] w_ar_off;
  logic        w_wr_elig;
  logic        w_rd_elig;

  assign w_aw_off  = (S_AXI_AWADDR - C_BASEADDR) & LP_OFF_MASK;
  assign w_ar_off  = (S_AXI_ARADDR - C_BASEADDR) & LP_OFF_MASK;
  // A lone AWVALID is never accepted: address and data are taken together.
  assign w_wr_elig = S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_elig = S_AXI_ARVALID;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state    <= S_IDLE;
      r_wr_ready <= 1'b0;
      r_ar_ready <= 1'b0;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_last_wr  <= 1'b0;
      r_en       <= 1'b0;
      r_wen      <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_wr_ready) begin
            r_wr_ready <= 1'b0;
            if (w_wr_elig) begin
              r_addr    <= C_PORT_AWIDTH'(w_aw_off);
              r_dout    <= S_AXI_WDATA;
              r_wen     <= S_AXI_WSTRB;
              r_en      <= 1'b1;
              r_last_wr <= 1'b1;
              r_state   <= S_WR_BRAM;
            end
          end else if (r_ar_ready) begin
            r_ar_ready <= 1'b0;
            if (w_rd_elig) begin
              r_addr    <= C_PORT_AWIDTH'(w_ar_off);
              r_wen     <= '0;
              r_en      <= 1'b1;
              r_last_wr <= 1'b0;
              r_state   <= S_RD_BRAM;
            end
          end else if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
            // Round-robin: on contention the write wins only if a read went last.
            r_wr_ready <= 1'b1;
          end else if (w_rd_elig) begin
            r_ar_ready <= 1'b1;
          end
        end
        S_WR_BRAM: begin
          r_en     <= 1'b0;
          r_wen    <= '0;
          r_bvalid <= 1'b1;
          r_state  <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD_BRAM: begin
          r_en    <= 1'b0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // BRAM output is valid one cycle after the enabled read edge.
          r_rdata  <= BRAM_Din;
          r_rvalid <= 1'b1;
          r_state  <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_wr_ready;
  assign S_AXI_WREADY  = r_wr_ready;
  assign S_AXI_ARREADY = r_ar_ready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = r_rdata;
  // Ascending BRAM ranges: vector assignment maps AXI bit 31 onto BRAM bit 0.
  assign BRAM_Rst      = S_AXI_ARESET;
  assign BRAM_Clk      = S_AXI_ACLK;
  assign BRAM_EN       = r_en;
  assign BRAM_WEN      = r_wen;
  assign BRAM_Addr     = r_addr;
  assign BRAM_Dout     = r_dout;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_bram_ctrl
//   Self-checking bench for axi_lite_bram_ctrl with a behavioural BRAM port
//   (read-first, byte write enables, big-endian lane order).
// ---------------------------------------------------------------------------
module tb_axi_lite_bram_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        bram_rst;
  logic        bram_clk;
  logic        bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr;
  logic [0:31] bram_dout;
  logic [0:31] bram_din;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_lite_bram_ctrl dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .BRAM_Rst      (bram_rst),
    .BRAM_Clk      (bram_clk),
    .BRAM_EN       (bram_en),
    .BRAM_WEN      (bram_wen),
    .BRAM_Addr     (bram_addr),
    .BRAM_Dout     (bram_dout),
    .BRAM_Din      (bram_din),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- BRAM model ----------------
  logic [31:0] mem [0:4095];
  logic [31:0] din_r;
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;
  logic [31:0] m_addr;
  logic [31:0] m_dout;
  logic [3:0]  m_we;

  assign m_addr   = bram_addr;
  assign m_dout   = bram_dout;
  assign m_we     = bram_wen;   // m_we[3] is BRAM lane 0 = most significant byte
  assign bram_din = din_r;

  always @(posedge bram_clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[m_addr[13:2]][8*b +: 8] <= m_dout[8*b +: 8];
      din_r <= mem[m_addr[13:2]];
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = byte_addr[13:2]; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic start_read(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
  endtask

  // Returns 1 for a write grant, 2 for a read grant, 3 for an illegal mix,
  // 0 if nothing was granted within the budget.
  task automatic wait_grant(output int kind);
    kind = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready || arready) begin
        if (awready && wready && !arready) kind = 1;
        else if (arready && !awready && !wready) kind = 2;
        else kind = 3;
        break;
      end
    end
  endtask

  // Called on the negedge where AWREADY/WREADY is seen high.
  task automatic finish_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int delay);
    logic [31:0] exp_addr;
    exp_addr = a & 32'h0000_3FFC;
    exp_q.push_back(32'h0);               // expected BRESP
    @(negedge clk);                        // WR_BRAM
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_en",    {31'b0, bram_en}, 32'h1);
    check_eq("wr_wen",   {28'b0, bram_wen}, {28'b0, s});
    check_eq("wr_addr",  bram_addr, exp_addr);
    check_eq("wr_dout",  bram_dout, d);
    check_eq("wr_lane0", {24'b0, bram_dout[0:7]}, {24'b0, d[31:24]});
    check_eq("wr_bvalid_early", {31'b0, bvalid}, 32'h0);
    @(negedge clk);                        // WR_RESP
    check_eq("wr_en_off", {31'b0, bram_en}, 32'h0);
    check_eq("wr_bvalid", {31'b0, bvalid}, 32'h1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("wr_bvalid_hold", {31'b0, bvalid}, 32'h1);
    end
    bready = 1'b1;
    if (exp_q.size() > 0) check_eq("bresp", {30'b0, bresp}, exp_q.pop_front());
    else check_eq("bresp_queue", 32'h0, 32'h1);
    @(negedge clk);
    bready = 1'b0;
    check_eq("wr_bvalid_done", {31'b0, bvalid}, 32'h0);
    check_eq("wr_idle", {29'b0, dbg_state}, 32'h0);
  endtask

  // Called on the negedge where ARREADY is seen high.
  task automatic finish_read(input logic [31:0] a, input logic [31:0] d, input int delay);
    logic [31:0] exp_addr;
    exp_addr = a & 32'h0000_3FFC;
    exp_q.push_back(d);
    @(negedge clk);                        // RD_BRAM (handshake edge T passed)
    arvalid = 1'b0;
    check_eq("rd_en",   {31'b0, bram_en}, 32'h1);
    check_eq("rd_wen",  {28'b0, bram_wen}, 32'h0);
    check_eq("rd_addr", bram_addr, exp_addr);
    @(negedge clk);                        // RD_WAIT
    check_eq("rd_rvalid_early", {31'b0, rvalid}, 32'h0);
    @(negedge clk);                        // RD_RESP: RVALID seen at edge T+3
    check_eq("rd_rvalid", {31'b0, rvalid}, 32'h1);
    check_eq("rd_rresp",  {30'b0, rresp}, 32'h0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("rd_rvalid_hold", {31'b0, rvalid}, 32'h1);
      if (exp_q.size() > 0) check_eq("rd_rdata_hold", rdata, exp_q[0]);
      check_eq("rd_en_hold", {31'b0, bram_en}, 32'h0);
    end
    rready = 1'b1;
    if (exp_q.size() > 0) check_eq("rdata", rdata, exp_q.pop_front());
    else check_eq("rdata_queue", 32'h0, 32'h1);
    @(negedge clk);
    rready = 1'b0;
    check_eq("rd_rvalid_done", {31'b0, rvalid}, 32'h0);
    check_eq("rd_idle", {29'b0, dbg_state}, 32'h0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int delay);
    int k;
    start_write(a, d, s);
    wait_grant(k);
    check_eq("wr_grant", k, 1);
    if (k == 1) finish_write(a, d, s, delay);
    else begin awvalid = 1'b0; wvalid = 1'b0; end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input int delay);
    int k;
    start_read(a);
    wait_grant(k);
    check_eq("rd_grant", k, 2);
    if (k == 2) finish_read(a, d, delay);
    else arvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [31:0] rd_d;
    rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_awready", {31'b0, awready}, 32'h0);
    check_eq("rst_arready", {31'b0, arready}, 32'h0);
    check_eq("rst_bvalid",  {31'b0, bvalid}, 32'h0);
    check_eq("rst_rvalid",  {31'b0, rvalid}, 32'h0);
    check_eq("rst_en",      {31'b0, bram_en}, 32'h0);
    check_eq("rst_addr",    bram_addr, 32'h0);
    check_eq("rst_dout",    bram_dout, 32'h0);
    check_eq("rst_rdata",   rdata, 32'h0);
    check_eq("rst_bram_rst", {31'b0, bram_rst}, 32'h1);
    rst = 1'b0;

    preload(32'h20,   32'h1122_3344);
    preload(32'h3FFC, 32'hCAFE_F00D);
    for (int i = 0; i < 2; i++) preload(32'h200 + 4*i, 32'hA5A5_0000 + i);

    // Full-word write, big-endian lane mapping, and read-back.
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    axi_read(32'h10, 32'hDEAD_BEEF, 0);

    // Single-lane write merges into a preloaded word.
    axi_write(32'h20, 32'h0000_00AA, 4'b0001, 1);
    axi_read(32'h20, 32'h1122_33AA, 0);

    // Zero strobe: enabled cycle, no byte written.
    axi_write(32'h20, 32'hFFFF_FFFF, 4'b0000, 0);
    axi_read(32'h20, 32'h1122_33AA, 0);

    // Top word of the window with RREADY held off for 5 cycles.
    axi_read(32'h3FFC, 32'hCAFE_F00D, 5);

    // Wrap and alignment: 0x4003 lands on offset 0.
    axi_write(32'h4003, 32'h5566_7788, 4'hF, 2);
    axi_read(32'h0, 32'h5566_7788, 0);

    // Random single-lane writes at offset 0x40, tracked by a byte model.
    rd_d = 32'h0;
    axi_write(32'h40, 32'h0, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) if (s[b]) rd_d[8*b +: 8] = d[8*b +: 8];
      axi_write(32'h40, d, s, $urandom_range(0, 2));
    end
    axi_read(32'h40, rd_d, 0);

    // Contention: AW/W and AR together; grants alternate starting with write.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      start_write(32'h100 + 4*i, 32'h0BAD_0000 + i, 4'hF);
      start_read(32'h200 + 4*(i/2));
      wait_grant(k);
      check_eq("arb_grant", k, (i % 2 == 0) ? 1 : 2);
      if (k == 1) begin
        arvalid = 1'b0;
        finish_write(32'h100 + 4*i, 32'h0BAD_0000 + i, 4'hF, 0);
      end else if (k == 2) begin
        awvalid = 1'b0; wvalid = 1'b0;
        finish_read(32'h200 + 4*(i/2), 32'hA5A5_0000 + (i/2), 0);
      end else begin
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      end
    end
    axi_read(32'h108, 32'h0BAD_0002, 0);

    // Reset during RD_WAIT drops the read without a response.
    start_read(32'h3FFC);
    wait_grant(k);
    check_eq("rst_rd_grant", k, 2);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check_eq("rst_rd_state", {29'b0, dbg_state}, 32'h4);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_en",      {31'b0, bram_en}, 32'h0);
    check_eq("mid_rst_rvalid",  {31'b0, rvalid}, 32'h0);
    check_eq("mid_rst_arready", {31'b0, arready}, 32'h0);
    check_eq("mid_rst_state",   {29'b0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_rvalid", {31'b0, rvalid}, 32'h0);
    end
    axi_read(32'h3FFC, 32'hCAFE_F00D, 0);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
